// File: rtl/serial_alu.sv
// Bit-serial 2-bit-per-cycle ALU and rotation sequencer for the serial register file.
// Optional immediate operand path enabled by defining SERIAL_ALU_IMM_EN.
module serial_alu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [1:0]      rs1_data,
  input  logic [1:0]      rs2_data,
  input  logic            imm_sel,
  input  logic [XLEN-1:0] imm,
  output logic [1:0]      rd_data,
  output logic            shift,
  output logic            wr_en,
  output logic            busy,
  output logic            done,
  output logic            flag_eq,
  output logic            flag_lt,
  output logic            flag_ltu
);
  localparam int DIGITS = XLEN / 2;
  localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt;
  logic [2:0]      op_r;
  logic            carry;
  logic            cmp_c;
  logic            ne;
  logic [1:0]      b;
  logic [1:0]      bp;
  logic [2:0]      sum;
  logic [2:0]      csum;
  logic            inv;
  logic            is_cmp;
  logic            last;
  logic            ovf;

  assign inv    = (op_r == 3'b001) || (op_r[2:1] == 2'b11);
  assign is_cmp = (op_r[2:1] == 2'b11);
  assign last   = (cnt == CW'(DIGITS - 1));

`ifdef SERIAL_ALU_IMM_EN
  logic            imm_sel_r;
  logic [XLEN-1:0] imm_sh;

  always_ff @(posedge clk) begin
    if (rst) begin
      imm_sel_r <= 1'b0;
      imm_sh    <= '0;
    end else if (state == IDLE && start) begin
      imm_sel_r <= imm_sel;
      imm_sh    <= imm;
    end else if (state == RUN) begin
      imm_sh    <= imm_sh >> 2;
    end
  end

  assign b = imm_sel_r ? imm_sh[1:0] : rs2_data;
`else
  assign b = rs2_data;
`endif

  // Main adder serves ADD/SUB/CMP; the compare path always computes A-B for the flags.
  assign bp   = inv ? ~b : b;
  assign sum  = {1'b0, rs1_data} + {1'b0, bp} + {2'b00, carry};
  assign csum = {1'b0, rs1_data} + {1'b0, ~b} + {2'b00, cmp_c};
  assign ovf  = (rs1_data[1] == ~b[1]) && (csum[1] != rs1_data[1]);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    shift   = (state == RUN);
    busy    = (state == RUN);
    wr_en   = (state == RUN) && !is_cmp;
    done    = (state == DONE);
    rd_data = 2'b00;
    if (state == RUN) begin
      case (op_r)
        3'b010:  rd_data = rs1_data & b;
        3'b011:  rd_data = rs1_data | b;
        3'b100:  rd_data = rs1_data ^ b;
        3'b101:  rd_data = b;
        default: rd_data = sum[1:0];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      op_r     <= 3'b000;
      carry    <= 1'b0;
      cmp_c    <= 1'b0;
      ne       <= 1'b0;
      flag_eq  <= 1'b0;
      flag_lt  <= 1'b0;
      flag_ltu <= 1'b0;
    end else if (state == IDLE && start) begin
      cnt      <= '0;
      op_r     <= op;
      carry    <= (op == 3'b001) || (op[2:1] == 2'b11);
      cmp_c    <= 1'b1;
      ne       <= 1'b0;
      flag_eq  <= 1'b0;
      flag_lt  <= 1'b0;
      flag_ltu <= 1'b0;
    end else if (state == RUN) begin
      cnt   <= cnt + 1'b1;
      carry <= sum[2];
      cmp_c <= csum[2];
      ne    <= ne | (rs1_data != b);
      // Flags land on the edge into DONE from the final digit's compare result.
      if (last) begin
        flag_eq  <= ~(ne | (rs1_data != b));
        flag_lt  <= csum[1] ^ ovf;
        flag_ltu <= ~csum[2];
      end
    end
  end
endmodule

// File: doc/serial_alu.md
Name: serial_alu

Overview:
- Bit-serial 2-bit-per-cycle ALU and sequencer that sits directly downstream of the serial register file.
- Consumes the regfile's 2-bit read digits and produces the 2-bit write digit, LSB digit first.
- Drives the regfile's shift and write-enable strobes for one full XLEN/2-cycle rotation per operation.
- Produces compare flags (eq, lt, ltu) for the branch/control unit.

Parameters:
- XLEN, 32, operand width in bits; must be even; one operation takes XLEN/2 RUN cycles.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset (top level drives the regfile's rst_n as its inverse)
- start  in  1  begin operation; sampled only in IDLE
- op  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 PASSB, 110 CMP, 111 CMP
- rs1_data  in  2  current digit of operand A (regfile r_value1)
- rs2_data  in  2  current digit of operand B (regfile r_value2)
- imm_sel  in  1  1 = operand B from immediate; sampled at start
- imm  in  XLEN  immediate value; captured at start
- rd_data  out  2  result digit (regfile write_value); combinational
- shift  out  1  rotate regfile one digit (regfile shift)
- wr_en  out  1  write rd_data into destination MSB digit (regfile wr_en)
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse after the last digit
- flag_eq  out  1  A == B
- flag_lt  out  1  A < B, signed
- flag_ltu  out  1  A < B, unsigned

Behaviour:
- Reset values: state IDLE, counter 0, carry 0, all outputs 0; op, imm_sel and imm_sh registers cleared.
- States:
  - IDLE: start=1 latches op and imm_sel, loads imm_sh=imm, sets carry = (op is SUB or CMP), counter=0, then goes to RUN. start=0 stays in IDLE.
  - RUN: shift=1, busy=1. Counter increments each cycle; at counter==XLEN/2-1 go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- Latency: start in cycle 0 gives RUN in cycles 1..16 and done in cycle 17 (XLEN=32). start is ignored outside IDLE.
- Operand B digit: b = imm_sel ? imm_sh[1:0] : rs2_data. imm_sh shifts right 2 each RUN cycle.
- Arithmetic per digit:
  - SUB and CMP use b' = ~b; ADD uses b' = b.
  - {cout, s} = rs1_data + b' + carry, 3-bit result; carry <= cout registered each RUN cycle.
- rd_data:
  - ADD/SUB: s.
  - AND/OR/XOR: bitwise rs1_data op b.
  - PASSB: b.
  - CMP: s, but not written.
- wr_en = RUN && op != CMP (110/111). Register x0 protection stays in the regfile.
- rs1 == rd or rs2 == rd is safe: the digit is read at [1:0] before it is written at [31:30] in the same cycle.
- Flags (every op internally subtracts A−B in a parallel compare path, carry-in 1):
  - ne accumulates OR of (rs1_data != b) across all RUN cycles.
  - On the last digit: ovf = (a1 == b'1) && (s1 != a1); lt = s1 ^ ovf; ltu = ~cout.
  - flag_eq = ~ne.
  - Flags update at the DONE edge and hold until the next DONE. They are cleared at start.
- Wrap-around: after exactly XLEN/2 shifts the regfile is back at its original alignment. The sequencer never issues more or fewer shifts.
- Reset mid-RUN: next edge forces IDLE with shift=wr_en=0. The regfile is reset by the same top-level reset, so no partial rotation persists.

Optional Feature:
- Macro SERIAL_ALU_IMM_EN.
- Defined: imm_sel/imm path as above, with an XLEN-bit imm_sh register.
- Undefined: imm_sh register is removed, imm_sel and imm are ignored, and b = rs2_data always.

Test Plan:
- ADD: regs x1=5, x2=7, rd=x3, start with op=000 -> 16 cycles of shift=wr_en=1; done at cycle 17; x3=12; x1 and x2 unchanged; flag_ltu=1, flag_eq=0.
- SUB borrow: x1=0, x2=1, op=001 into x3 -> x3=0xFFFFFFFF; flag_lt=1, flag_ltu=1.
- CMP signed/unsigned: x1=0x80000000, x2=1, op=110 -> wr_en stays 0 all run; flag_lt=1, flag_ltu=0, flag_eq=0; regs unchanged after 16 shifts.
- Immediate PASSB (SERIAL_ALU_IMM_EN): imm=0xDEADBEEF, imm_sel=1, op=101, rd=x4 -> x4=0xDEADBEEF. Same test without the macro -> x4=x2's value.
- In-place and x0: op=000 with rs1=rd=x1=3, rs2=x1 -> x1=6. Same op with rd=x0 -> x0 stays 0.
- start during busy and reset: start pulsed at RUN cycle 5 is ignored (done only once, at cycle 17). rst at RUN cycle 8 -> next cycle busy=shift=wr_en=done=0, flags=0, state IDLE; a new start then runs normally.
